// File: rtl/axi_elastic_fifo.sv
// axi_elastic_fifo: registered elastic buffer for one AXI channel.
// Storage is an output register (m_data/m_valid) backed by a ring of
// DEPTH-1 entries. Every output is a flop, so there is no combinational path
// from s_* to m_*, and none from m_ready to s_ready.
module axi_elastic_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AF_TH = 3,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] o_count,
  output logic          o_almost_full
);

  localparam int RING = DEPTH - 1;
  localparam int PW   = (RING > 1) ? $clog2(RING) : 1;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_TH);
  localparam logic [PW-1:0] LAST_C = PW'(RING - 1);

  logic [DW-1:0] ring_q [RING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          push;
  logic          pop;
  logic          ring_nonempty;
  logic          load_out;
  logic          bypass;
  logic          ring_wr;
  logic [CW-1:0] count_nxt;

  // Ring pointers wrap by explicit compare so any DEPTH works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // Handshakes and next occupancy. The output register is full exactly when
  // count is nonzero, so the ring holds count-1 beats.
  always_comb begin
    push          = s_valid & s_ready;
    pop           = m_valid & m_ready;
    ring_nonempty = (o_count > CW'(1));
    load_out      = !m_valid || pop;
    bypass        = load_out && !ring_nonempty;
    ring_wr       = push && !bypass && !i_flush && !i_reset;
    count_nxt     = o_count + CW'(push) - CW'(pop);
  end

  // Control state and output register; reset beats flush, which beats handshakes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_count       <= '0;
      m_valid       <= 1'b0;
      s_ready       <= 1'b0;
      o_almost_full <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      m_data        <= '0;
    end else if (i_flush) begin
      o_count       <= '0;
      m_valid       <= 1'b0;
      s_ready       <= 1'b1;
      o_almost_full <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      o_count       <= count_nxt;
      m_valid       <= (count_nxt != '0);
      s_ready       <= (count_nxt < FULL_C);
      o_almost_full <= (count_nxt >= AF_C);
      if (load_out) begin
        if (ring_nonempty) begin
          m_data <= ring_q[rd_ptr];
          rd_ptr <= ptr_inc(rd_ptr);
        end else if (push) begin
          m_data <= s_data;
        end
      end
      if (ring_wr) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
    end
  end

  // Ring payload storage: a beat enters unless it bypasses straight to m_data.
  always_ff @(posedge i_clk) begin
    if (ring_wr) begin
      ring_q[wr_ptr] <= s_data;
    end
  end

endmodule

// File: doc/axi_elastic_fifo.md
Name: axi_elastic_fifo

Overview:
- Parametrised, fully registered elastic buffer for one AXI channel (AW/W/AR/R/B). It is the deeper successor to the 1-entry skid/register slice.
- Holds up to DEPTH beats in FIFO order at one beat per cycle.
- Registers all outputs: no combinational path from s_* to m_* or from m_ready to s_ready.
- Adds synchronous flush, occupancy count and almost-full flag, for interconnect boundaries that need slack for long routes or rate mismatch.

Parameters:
- DW, 8, payload width in bits (>=1).
- DEPTH, 4, total beat capacity including the output register (>=2; any integer, not only powers of two).
- AF_TH, 3, o_almost_full threshold (1..DEPTH).
- CW, $clog2(DEPTH+1), derived localparam; width of o_count. Not overridable.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous discard of all held beats.
- s_data  in  DW  upstream payload.
- s_valid  in  1  upstream valid.
- s_ready  out  1  upstream ready, registered.
- m_data  out  DW  downstream payload, registered.
- m_valid  out  1  downstream valid, registered.
- m_ready  in  1  downstream ready.
- o_count  out  CW  beats held, 0..DEPTH, registered.
- o_almost_full  out  1  registered, equals (o_count >= AF_TH).

Behaviour:
- Interface: one clock i_clk; reset i_reset is synchronous and active-high.
- Reset (i_reset=1 at an edge): next-cycle values are m_valid=0, m_data=0, s_ready=0, o_count=0, o_almost_full=0, storage pointers=0.
  - s_ready stays 0 for the first cycle after i_reset falls and goes 1 on the following edge.
  - i_reset dominates i_flush and all handshakes.
- Definitions: push = s_valid & s_ready; pop = m_valid & m_ready.
- Occupancy: count_next = count + push - pop. Push and pop in the same cycle leave the count unchanged. Count never exceeds DEPTH or goes below 0.
- Registered ready: s_ready <= (count_next < DEPTH), so s_ready falls on the edge where count reaches DEPTH.
  - At count==DEPTH no push is possible, even if m_ready=1 that cycle; ready returns one cycle after the pop.
  - Full throughput (1 beat/cycle) is sustained whenever count < DEPTH.
- Output register: m_valid <= (count_next != 0). m_data is loaded with the head beat whenever the output register is empty or pop occurs.
  - If a pop empties the internal ring and a push occurs in the same cycle, the pushed beat goes straight to m_data.
- Latency: a beat pushed into an empty buffer appears on m_data/m_valid exactly one cycle later. No same-cycle pass-through.
- Storage: the output register plus a ring of DEPTH-1 entries with write/read pointers. Pointers wrap from DEPTH-2 to 0 (non-power-of-two handled by explicit compare).
- Ordering: beats leave in push order with no loss or duplication.
- AXI stability: while m_valid=1 and m_ready=0, m_data and m_valid hold constant. m_valid never drops without a pop.
- Flush (i_flush=1 at an edge, i_reset=0):
  - Next cycle: count=0, m_valid=0, s_ready=1, pointers=0.
  - A push in the flush cycle is discarded; the upstream sees it as accepted.
  - A pop in the flush cycle counts as delivered.
  - m_data holds its last value (don't-care while m_valid=0).
  - Flushing while empty has no effect beyond forcing s_ready=1.
- o_almost_full is updated from count_next, in the same cycle as o_count.

Test Plan:
- Reset release, DEPTH=4, s_valid=1 held, s_data=0xA0 -> s_ready=0 in the cycle after reset and 1 the next. The first push appears on m_data=0xA0 with m_valid=1 one cycle later. o_count=1.
- Streaming: m_ready=1 and 100 back-to-back beats 0..99 -> m_data carries 0..99 in order on consecutive cycles. s_ready stays 1 throughout. o_count stays 1.
- Fill/stall, DEPTH=4, AF_TH=3: m_ready=0, push 0x11,0x22,0x33,0x44.
  - o_almost_full=1 after the 3rd push; o_count=4 and s_ready=0 after the 4th.
  - m_data stays at 0x11.
  - Then m_ready=1 -> outputs 0x11,0x22,0x33,0x44. s_ready is 1 again one cycle after the first pop.
- Simultaneous push+pop at count=3 (DEPTH=4) for 10 cycles -> o_count stays 3, s_ready stays 1, order is preserved.
- Flush with count=3 and a concurrent push of 0x55 -> the next cycle shows m_valid=0, o_count=0, s_ready=1. 0x55 never appears on m_data. The next pushed beat 0x66 appears one cycle after its push.
- DEPTH=3 (non-power-of-two): random s_valid/m_ready at 50% for 2000 beats -> the scoreboard shows the output sequence equals the input sequence. o_count always equals the outstanding beats and never exceeds 3.
